// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter with round-robin grant held for the whole CYC.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
`ifdef WB_ARB_TIMEOUT_EN
    parameter int TIMEOUT = 255,
`endif
    parameter int SEL_W   = DATA_W / 8
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              M0_CYC_I,
    input  logic              M0_STB_I,
    input  logic              M0_WE_I,
    input  logic [ADDR_W-1:0] M0_ADR_I,
    input  logic [DATA_W-1:0] M0_DAT_I,
    input  logic [SEL_W-1:0]  M0_SEL_I,
    output logic [DATA_W-1:0] M0_DAT_O,
    output logic              M0_ACK_O,
    output logic              M0_ERR_O,
    input  logic              M1_CYC_I,
    input  logic              M1_STB_I,
    input  logic              M1_WE_I,
    input  logic [ADDR_W-1:0] M1_ADR_I,
    input  logic [DATA_W-1:0] M1_DAT_I,
    input  logic [SEL_W-1:0]  M1_SEL_I,
    output logic [DATA_W-1:0] M1_DAT_O,
    output logic              M1_ACK_O,
    output logic              M1_ERR_O,
    output logic              S_CYC_O,
    output logic              S_STB_O,
    output logic              S_WE_O,
    output logic [ADDR_W-1:0] S_ADR_O,
    output logic [DATA_W-1:0] S_DAT_O,
    output logic [SEL_W-1:0]  S_SEL_O,
    input  logic [DATA_W-1:0] S_DAT_I,
    input  logic              S_ACK_I,
    input  logic              S_ERR_I,
    output logic [1:0]        GNT_O
);

    typedef enum logic [1:0] {
        IDLE,
        OWN_M0,
        OWN_M1
    } state_e;

    state_e state_q, state_d;
    // 1'b1 means M1 held the last grant, so M0 wins the next tie
    logic   last_gnt_q, last_gnt_d;
    logic   wd_hit;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (M0_CYC_I && (!M1_CYC_I || last_gnt_q)) begin
                    state_d    = OWN_M0;
                    last_gnt_d = 1'b0;
                end else if (M1_CYC_I) begin
                    state_d    = OWN_M1;
                    last_gnt_d = 1'b1;
                end
            end
            OWN_M0: if (!M0_CYC_I) state_d = IDLE;
            OWN_M1: if (!M1_CYC_I) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        S_CYC_O  = 1'b0;
        S_STB_O  = 1'b0;
        S_WE_O   = 1'b0;
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        S_SEL_O  = '0;
        M0_ACK_O = 1'b0;
        M0_ERR_O = 1'b0;
        M1_ACK_O = 1'b0;
        M1_ERR_O = 1'b0;
        case (state_q)
            OWN_M0: begin
                S_CYC_O  = M0_CYC_I;
                S_STB_O  = M0_STB_I && !wd_hit;
                S_WE_O   = M0_WE_I;
                S_ADR_O  = M0_ADR_I;
                S_DAT_O  = M0_DAT_I;
                S_SEL_O  = M0_SEL_I;
                M0_ACK_O = S_ACK_I;
                M0_ERR_O = S_ERR_I || wd_hit;
            end
            OWN_M1: begin
                S_CYC_O  = M1_CYC_I;
                S_STB_O  = M1_STB_I && !wd_hit;
                S_WE_O   = M1_WE_I;
                S_ADR_O  = M1_ADR_I;
                S_DAT_O  = M1_DAT_I;
                S_SEL_O  = M1_SEL_I;
                M1_ACK_O = S_ACK_I;
                M1_ERR_O = S_ERR_I || wd_hit;
            end
            default: ;
        endcase
    end

    assign M0_DAT_O = S_DAT_I;
    assign M1_DAT_O = S_DAT_I;
    assign GNT_O    = {state_q == OWN_M1, state_q == OWN_M0};

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    assign wd_hit = (state_q != IDLE) && (cnt_q == 16'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || S_ACK_I || S_ERR_I || wd_hit)
            cnt_d = '0;
        else if (S_STB_O)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign wd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: reset, single read, round robin,
// locked sequence, reset mid-transfer, watchdog / no-watchdog.
module tb_wb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_dat_i, m0_dat_o;
    logic [SW-1:0] m0_sel;
    logic          m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_dat_i, m1_dat_o;
    logic [SW-1:0] m1_sel;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic [SW-1:0] s_sel;
    logic          s_ack, s_err;
    logic [1:0]    gnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_arbiter_2m #(
        .ADDR_W (AW),
`ifdef WB_ARB_TIMEOUT_EN
        .TIMEOUT(8),
`endif
        .DATA_W (DW)
    ) dut (
        .CLK_I   (clk),
        .RST_I   (rst),
        .M0_CYC_I(m0_cyc),
        .M0_STB_I(m0_stb),
        .M0_WE_I (m0_we),
        .M0_ADR_I(m0_adr),
        .M0_DAT_I(m0_dat_i),
        .M0_SEL_I(m0_sel),
        .M0_DAT_O(m0_dat_o),
        .M0_ACK_O(m0_ack),
        .M0_ERR_O(m0_err),
        .M1_CYC_I(m1_cyc),
        .M1_STB_I(m1_stb),
        .M1_WE_I (m1_we),
        .M1_ADR_I(m1_adr),
        .M1_DAT_I(m1_dat_i),
        .M1_SEL_I(m1_sel),
        .M1_DAT_O(m1_dat_o),
        .M1_ACK_O(m1_ack),
        .M1_ERR_O(m1_err),
        .S_CYC_O (s_cyc),
        .S_STB_O (s_stb),
        .S_WE_O  (s_we),
        .S_ADR_O (s_adr),
        .S_DAT_O (s_dat_o),
        .S_SEL_O (s_sel),
        .S_DAT_I (s_dat_i),
        .S_ACK_I (s_ack),
        .S_ERR_I (s_err),
        .GNT_O   (gnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock, then step 1 ns past the edge before driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_g;
    logic       wd_exp;

    initial begin
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0;
        m0_dat_i = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0;
        m1_dat_i = '0; m1_sel = '0;
        s_dat_i = 32'h0000_1234; s_ack = 0; s_err = 0;

        // reset then idle
        tick(); tick();
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_scyc", 64'(s_cyc), 64'd0);
        chk("rst_sstb", 64'(s_stb), 64'd0);
        chk("rst_sadr", 64'(s_adr), 64'd0);
        chk("rst_acks", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
        chk("rst_dat", 64'(m1_dat_o), 64'h1234);
        rst = 1'b0;
        tick();

        // M0 single read
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0010_0004;
        m0_sel = 4'hF;
        #1;
        chk("rd_req_gnt", 64'(gnt), 64'd0);
        tick();
        s_ack = 1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        chk("rd_gnt", 64'(gnt), 64'b01);
        chk("rd_sadr", 64'(s_adr), 64'h0010_0004);
        chk("rd_ack0", 64'(m0_ack), 64'd1);
        chk("rd_dat0", 64'(m0_dat_o), 64'hDEAD_BEEF);
        chk("rd_ack1", 64'(m1_ack), 64'd0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        chk("rd_drop_hold", 64'(gnt), 64'b01);
        tick();
        #1;
        chk("rd_idle", 64'(gnt), 64'd0);

        // restart so last_gnt is back at M1
        rst = 1; tick(); tick(); rst = 0;

        // round robin, both masters re-request after each ACK
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0A00;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0B00;
        tick();
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            s_ack = 1;
            #1;
            chk($sformatf("rr%0d_gnt", i), 64'(gnt), 64'(exp_g));
            chk($sformatf("rr%0d_acks", i), 64'({m1_ack, m0_ack}),
                64'(exp_g));
            chk($sformatf("rr%0d_adr", i), 64'(s_adr),
                exp_g[0] ? 64'h0A00 : 64'h0B00);
            tick();
            s_ack = 0;
            if (exp_g[0]) begin m0_cyc = 0; m0_stb = 0; end
            else begin m1_cyc = 0; m1_stb = 0; end
            tick();
            #1;
            chk($sformatf("rr%0d_idle", i), 64'(gnt), 64'd0);
            if (i < 5) begin
                if (exp_g[0]) begin m0_cyc = 1; m0_stb = 1; end
                else begin m1_cyc = 1; m1_stb = 1; end
            end else begin
                m0_cyc = 0; m0_stb = 0;
            end
            tick();
        end

        // locked M1 sequence with M0 waiting
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0100_0000;
        tick();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0000_0C00;
        for (int b = 0; b < 4; b++) begin
            m1_dat_i = 32'h55 + 32'(b);
            s_ack = 1;
            #1;
            chk($sformatf("lk%0d_gnt", b), 64'(gnt), 64'b10);
            chk($sformatf("lk%0d_sdat", b), 64'({s_we, s_dat_o}),
                {31'd0, 1'b1, 32'h55 + 32'(b)});
            chk($sformatf("lk%0d_acks", b), 64'({m1_ack, m0_ack}),
                64'b10);
            tick();
            s_ack = 0;
            #1;
            chk($sformatf("lk%0d_hold", b), 64'(gnt), 64'b10);
            tick();
        end
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        #1;
        chk("lk_drop_gnt", 64'(gnt), 64'b10);
        tick();
        #1;
        chk("lk_idle", 64'({gnt, s_cyc}), 64'd0);
        tick();
        #1;
        chk("lk_m0_gnt", 64'(gnt), 64'b01);
        chk("lk_m0_slave", 64'({s_cyc, s_stb, s_adr}),
            {30'd0, 2'b11, 32'h0000_0C00});

        // reset during stalled M0 cycle, M1 also waiting
        m1_cyc = 1; m1_stb = 1;
        rst = 1;
        tick();
        #1;
        chk("mr_scyc", 64'(s_cyc), 64'd0);
        chk("mr_gnt", 64'(gnt), 64'd0);
        rst = 0;
        tick();
        #1;
        chk("mr_tie_m0", 64'(gnt), 64'b01);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick(); tick();

        // stalled slave: watchdog or endless wait
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0D00;
        tick();
        for (int k = 0; k <= 10; k++) begin
`ifdef WB_ARB_TIMEOUT_EN
            wd_exp = (k == 8);
`else
            wd_exp = 1'b0;
`endif
            #1;
            chk($sformatf("wd%0d_err", k), 64'({m1_err, m0_err}),
                64'(wd_exp));
            chk($sformatf("wd%0d_stb", k), 64'(s_stb), 64'(!wd_exp));
            tick();
        end
        #1;
        chk("wd_gnt_kept", 64'(gnt), 64'b01);
        s_err = 1;
        #1;
        chk("serr_pass", 64'({m1_err, m0_err}), 64'b01);
        s_err = 0;
        m0_cyc = 0; m0_stb = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone classic arbiter that shares one slave port (the data RAM / peripheral fabric behind `wb_ram_inst`) between the dtcore32 data-memory port (M0) and a second bus master such as a UART program loader or DMA (M1). It sits between the masters and the SoC address decoder in `soc_top`. It grants the slave to one master at a time with round-robin fairness and holds the grant for the whole bus cycle (CYC high). An optional watchdog terminates transfers that the slave never acknowledges.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `SEL_W = DATA_W/8`
- `TIMEOUT`, 255, watchdog limit in cycles (only with `WB_ARB_TIMEOUT_EN`), range 2..65535

- `CLK_I` in 1: single clock, all logic on rising edge
- `RST_I` in 1: synchronous, active-high reset
- `M0_CYC_I`, `M0_STB_I`, `M0_WE_I` in 1 each: master 0 (CPU data port) cycle, strobe, write enable
- `M0_ADR_I` in ADDR_W, `M0_DAT_I` in DATA_W, `M0_SEL_I` in SEL_W: master 0 address, write data, byte select
- `M0_DAT_O` out DATA_W, `M0_ACK_O` out 1, `M0_ERR_O` out 1: master 0 read data, ack, error
- `M1_*`: identical set for master 1
- `S_CYC_O`, `S_STB_O`, `S_WE_O` out 1 each; `S_ADR_O` out ADDR_W; `S_DAT_O` out DATA_W; `S_SEL_O` out SEL_W: slave-side request
- `S_DAT_I` in DATA_W, `S_ACK_I` in 1, `S_ERR_I` in 1: slave response
- `GNT_O` out 2: one-hot current grant (bit0 = M0, bit1 = M1), 2'b00 when idle

## Operation
- FSM states: IDLE, OWN_M0, OWN_M1 (registered).
- IDLE: slave outputs all zero; no master sees ACK/ERR.
- IDLE -> OWN_Mx at clock edge when request present. Requests: `Mx_CYC_I`.
  - Only one requests: grant it.
  - Both request: grant the master not granted last (`last_gnt` register). After reset `last_gnt` = M1, so M0 wins the first tie.
  - `last_gnt` updated at grant time.
- OWN_Mx: S_CYC/STB/WE/ADR/DAT/SEL = Mx inputs (combinational mux from state). `Mx_ACK_O = S_ACK_I`, `Mx_ERR_O = S_ERR_I`. The non-granted master sees ACK = ERR = 0.
- `M0_DAT_O = M1_DAT_O = S_DAT_I` unconditionally.
- OWN_Mx -> IDLE when `Mx_CYC_I` = 0. Grant held across multiple STB/ACK beats while CYC stays high (RMW/locked sequences).
- No OWN_M0 <-> OWN_M1 direct transition: always via IDLE (one dead cycle).
- A master dropping CYC mid-transfer before ACK aborts the cycle. The arbiter releases regardless of slave state.
- Reset mid-transfer: state -> IDLE, `last_gnt` -> M1, and the outstanding transfer is discarded; slave sees CYC=0 next cycle.

## Timing
- Reset values: `GNT_O` = 0; all `S_*_O` = 0; `M*_ACK_O` = `M*_ERR_O` = 0; `M*_DAT_O` follows `S_DAT_I`.
- Arbitration latency: request in cycle N -> slave sees CYC/STB in cycle N+1.
- Response path combinational: `S_ACK_I` in cycle K -> `Mx_ACK_O` in cycle K.
- Minimum single access: 2 cycles (arbitrate + zero-wait-state ACK). Back-to-back from another master: +1 idle cycle.
- Master CYC drop at cycle K -> IDLE at K+1; a pending other master is granted at K+2 and seen by the slave at K+2.

## Configuration
- Macro `WB_ARB_TIMEOUT_EN`.
- Defined:
  - 16-bit counter resets on grant and on each `S_ACK_I`/`S_ERR_I`. It increments each cycle in OWN_Mx with `S_STB_O` = 1.
  - When the counter equals `TIMEOUT`, `Mx_ERR_O` = 1 and `S_STB_O` = 0 for that one cycle, then the counter clears.
  - The grant persists until the master drops CYC.
- Undefined: no counter; the arbiter waits on the slave indefinitely.

## Test plan
- Reset then idle: `RST_I` = 1 for 2 cycles -> all outputs 0, `GNT_O` = 00.
- M0 single read: M0 read at 0x0010_0004, slave ACKs with 0xDEADBEEF on its first cycle -> `GNT_O` = 01 one cycle after request; `M0_ACK_O` = 1 with `M0_DAT_O` = 0xDEADBEEF; M1 ACK stays 0.
- Simultaneous requests, 3 rounds:
  - Both masters hold CYC and re-request after each ACK.
  - Required grant order: M0, M1, M0, M1, M0, M1.
  - Exactly one IDLE cycle between grants.
- Locked sequence:
  - M1 keeps CYC high across 4 writes to 0x0100_0000 (UART) while M0 requests.
  - M0 must not be granted until M1 drops CYC.
  - M0 is then seen at the slave exactly 2 cycles later.
- Reset mid-transfer: `RST_I` asserted while in OWN_M0 with slave stalling -> next cycle `S_CYC_O` = 0, `GNT_O` = 00; after release, a tie is granted to M0.
- Watchdog (`WB_ARB_TIMEOUT_EN`, `TIMEOUT` = 8): slave never ACKs -> `M0_ERR_O` pulses one cycle exactly 8 cycles after the strobe reached the slave. Without the macro, no ERR ever appears.
